// File: rtl/mmr_mismatch_monitor.sv
// mmr_mismatch_monitor
// Watches the replica outputs and mismatch flag of an upstream mmr_register.
// Produces a registered majority vote with a per-replica fault map and keeps
// saturating upset statistics. When a mismatch persists it raises a scrub
// request so that control logic can rewrite the register.
//
// Scrub handshake: scrub_req_o is a registered level that rises once a
// mismatch has persisted long enough. It stays high until scrub_ack_i is
// sampled high on a clock edge. scrub_req_o falls on that same edge.
// scrub_ack_i is ignored while no request is pending. A new request is only
// possible after the mismatch has been seen low for at least one edge.
module mmr_mismatch_monitor #(
    parameter int   K_MMR          = 3,
    parameter int   CNT_WIDTH      = 16,
    parameter int   PERSIST_CYCLES = 4,
    parameter logic RESET_VALUE    = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 Q_i [K_MMR-1:0],
    input  logic                 mismatch_i,
    input  logic                 clear_i,
    input  logic                 scrub_ack_i,
    output logic                 voted_o,
    output logic [K_MMR-1:0]     faulty_o,
    output logic [CNT_WIDTH-1:0] event_cnt_o,
    output logic [CNT_WIDTH-1:0] cycle_cnt_o,
    output logic                 scrub_req_o,
    output logic [1:0]           fsm_state_o
);

    // Reject parameter values that make the vote or the threshold meaningless.
    if (K_MMR < 3 || (K_MMR % 2) == 0) begin : g_bad_k_mmr
        $error("mmr_mismatch_monitor: K_MMR must be odd and >= 3");
    end
    if (PERSIST_CYCLES < 1 || PERSIST_CYCLES > 255) begin : g_bad_persist
        $error("mmr_mismatch_monitor: PERSIST_CYCLES must be in 1..255");
    end

    localparam int                   PW         = $clog2(K_MMR + 1);
    localparam logic [PW-1:0]        HALF       = PW'(K_MMR / 2);
    localparam logic [7:0]           PERSIST_LIM = 8'(PERSIST_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PERSIST    = 2'd1,
        REQ        = 2'd2,
        WAIT_CLEAR = 2'd3
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [7:0]      pcnt;
    logic [7:0]      pcnt_d;
    logic            scrub_req_d;
    logic            mm_r;
    logic            mm_prev;
    logic [PW-1:0]   ones;
    logic            majority;
    logic [K_MMR-1:0] faulty_d;

    // Majority vote: count ones, flag every replica that disagrees with the result.
    always_comb begin
        ones     = '0;
        faulty_d = '0;
        for (int k = 0; k < K_MMR; k++) begin
            ones = ones + PW'(Q_i[k]);
        end
        majority = (ones > HALF);
        for (int k = 0; k < K_MMR; k++) begin
            faulty_d[k] = Q_i[k] ^ majority;
        end
    end

    // Register the vote and fault map (one cycle of latency from Q_i).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            voted_o  <= RESET_VALUE;
            faulty_o <= '0;
        end else begin
            voted_o  <= majority;
            faulty_o <= faulty_d;
        end
    end

    // Input stage: mismatch_i only enters the logic through these two flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mm_r    <= 1'b0;
            mm_prev <= 1'b0;
        end else begin
            mm_r    <= mismatch_i;
            mm_prev <= mm_r;
        end
    end

    // Saturating statistics. A clear overrides any increment on the same edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycle_cnt_o <= '0;
            event_cnt_o <= '0;
        end else if (clear_i) begin
            cycle_cnt_o <= '0;
            event_cnt_o <= '0;
        end else begin
            if (mm_r && cycle_cnt_o != CNT_MAX) begin
                cycle_cnt_o <= cycle_cnt_o + CNT_WIDTH'(1);
            end
            if (mm_r && !mm_prev && event_cnt_o != CNT_MAX) begin
                event_cnt_o <= event_cnt_o + CNT_WIDTH'(1);
            end
        end
    end

    // FSM state register, persistence counter and registered request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            pcnt        <= '0;
            scrub_req_o <= 1'b0;
        end else begin
            state       <= state_d;
            pcnt        <= pcnt_d;
            scrub_req_o <= scrub_req_d;
        end
    end

    // FSM next-state logic: count consecutive mismatch samples, then request.
    always_comb begin
        state_d = state;
        pcnt_d  = pcnt;
        unique case (state)
            IDLE: begin
                if (mm_r) begin
                    state_d = PERSIST;
                    pcnt_d  = 8'd1;
                end
            end
            PERSIST: begin
                if (!mm_r) begin
                    state_d = IDLE;
                    pcnt_d  = '0;
                end else if (pcnt == PERSIST_LIM) begin
                    state_d = REQ;
                end else begin
                    pcnt_d = pcnt + 8'd1;
                end
            end
            REQ: begin
                // Once raised, the request is held until acknowledged.
                if (scrub_ack_i) begin
                    state_d = WAIT_CLEAR;
                end
            end
            WAIT_CLEAR: begin
                // Wait for the fault to go away so it is not requested twice.
                if (!mm_r) begin
                    state_d = IDLE;
                    pcnt_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                pcnt_d  = '0;
            end
        endcase
    end

    // FSM output logic: the request flop is high exactly while in REQ.
    always_comb begin
        scrub_req_d = (state_d == REQ);
    end

    assign fsm_state_o = state;

endmodule

// File: tb/tb_mmr_mismatch_monitor.sv
// Testbench for mmr_mismatch_monitor: table-driven voting checks through an
// expected-value queue, plus hand-written sequences for persistence, the
// scrub handshake, counter saturation/clear and reset during a request.
module tb_mmr_mismatch_monitor;

    localparam int W = 6; // {voted, faulty[4:0]}

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_REQ        = 2'd2;
    localparam logic [1:0] S_WAIT_CLEAR = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic       q3 [2:0];
    logic       q5 [4:0];
    logic       mm;
    logic       clr;
    logic       ack;

    logic       voted3;
    logic [2:0] faulty3;
    logic [3:0] event_cnt3;
    logic [3:0] cycle_cnt3;
    logic       req3;
    logic [1:0] state3;

    logic       voted5;
    logic [4:0] faulty5;
    logic [3:0] event_cnt5;
    logic [3:0] cycle_cnt5;
    logic       req5;
    logic [1:0] state5;

    mmr_mismatch_monitor #(
        .K_MMR(3), .CNT_WIDTH(4), .PERSIST_CYCLES(4), .RESET_VALUE(1'b0)
    ) dut (
        .clk_i(clk), .rst_i(rst), .Q_i(q3), .mismatch_i(mm), .clear_i(clr),
        .scrub_ack_i(ack), .voted_o(voted3), .faulty_o(faulty3),
        .event_cnt_o(event_cnt3), .cycle_cnt_o(cycle_cnt3),
        .scrub_req_o(req3), .fsm_state_o(state3)
    );

    mmr_mismatch_monitor #(
        .K_MMR(5), .CNT_WIDTH(4), .PERSIST_CYCLES(4), .RESET_VALUE(1'b0)
    ) dut5 (
        .clk_i(clk), .rst_i(rst), .Q_i(q5), .mismatch_i(mm), .clear_i(clr),
        .scrub_ack_i(ack), .voted_o(voted5), .faulty_o(faulty5),
        .event_cnt_o(event_cnt5), .cycle_cnt_o(cycle_cnt5),
        .scrub_req_o(req5), .fsm_state_o(state5)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_q3(input logic [2:0] p);
        for (int k = 0; k < 3; k++) q3[k] = p[k];
    endtask

    task automatic drive_q5(input logic [4:0] p);
        for (int k = 0; k < 5; k++) q5[k] = p[k];
    endtask

    // ---------------- vector table ----------------
    // q bit k is replica k. sel5 selects the five-replica instance.
    typedef struct {
        logic       sel5;
        logic [4:0] q;
        logic       exp_v;
        logic [4:0] exp_f;
    } vec_t;

    vec_t vecs[11];

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic       seen;
        logic [W-1:0] exp_w;
        logic [W-1:0] act_w;

        vecs[0]  = '{1'b0, 5'b00111, 1'b1, 5'b00000};
        vecs[1]  = '{1'b0, 5'b00110, 1'b1, 5'b00001}; // Q={0,1,1}
        vecs[2]  = '{1'b0, 5'b00001, 1'b0, 5'b00001}; // Q={1,0,0}
        vecs[3]  = '{1'b0, 5'b00000, 1'b0, 5'b00000};
        vecs[4]  = '{1'b0, 5'b00010, 1'b0, 5'b00010};
        vecs[5]  = '{1'b0, 5'b00011, 1'b1, 5'b00100};
        vecs[6]  = '{1'b0, 5'b00100, 1'b0, 5'b00100};
        vecs[7]  = '{1'b0, 5'b00101, 1'b1, 5'b00010};
        vecs[8]  = '{1'b1, 5'b10011, 1'b1, 5'b01100}; // Q={1,1,0,0,1}
        vecs[9]  = '{1'b1, 5'b00111, 1'b1, 5'b11000};
        vecs[10] = '{1'b1, 5'b00011, 1'b0, 5'b00011};

        drive_q3(3'b000);
        drive_q5(5'b00000);
        mm  = 1'b0;
        clr = 1'b0;
        ack = 1'b0;
        rst = 1'b1;

        // ---- reset state ----
        repeat (2) tick();
        check("rst_voted", voted3, 0);
        check("rst_faulty", faulty3, 0);
        check("rst_event", event_cnt3, 0);
        check("rst_cycle", cycle_cnt3, 0);
        check("rst_req", req3, 0);
        check("rst_state", state3, S_IDLE);
        rst = 1'b0;
        tick();

        // ---- voting table through the expected queue ----
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].sel5) drive_q5(vecs[i].q);
            else              drive_q3(vecs[i].q[2:0]);
            exp_q.push_back({vecs[i].exp_v, vecs[i].exp_f});
            tick();
            exp_w = exp_q.pop_front();
            act_w = vecs[i].sel5 ? {voted5, faulty5} : {voted3, 2'b00, faulty3};
            check($sformatf("vote[%0d]", i), 32'(act_w), 32'(exp_w));
        end

        // ---- glitch filtering ----
        seen = 1'b0;
        mm = 1'b1;
        tick();
        mm = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | req3;
        end
        check("glitch_no_req", seen, 0);
        check("glitch_event", event_cnt3, 1);
        check("glitch_cycle", cycle_cnt3, 1);
        check("glitch_state", state3, S_IDLE);

        // ---- persistent fault and handshake ----
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clear_event", event_cnt3, 0);
        check("clear_cycle", cycle_cnt3, 0);

        seen = 1'b0;
        mm = 1'b1;
        for (int e = 0; e <= 4; e++) begin   // edges 0..4
            tick();
            seen = seen | req3;
        end
        check("persist_early_req", seen, 0);
        tick();                              // edge 5
        check("persist_req_e5", req3, 1);
        check("persist_state_req", state3, S_REQ);
        tick();                              // edge 6
        tick();                              // edge 7
        check("persist_req_hold", req3, 1);
        ack = 1'b1;
        tick();                              // edge 8
        ack = 1'b0;
        mm = 1'b0;
        check("ack_req_low", req3, 0);
        check("ack_state", state3, S_WAIT_CLEAR);
        tick();                              // edge 9, mismatch still seen high
        check("no_rerequest", req3, 0);
        check("wait_clear_hold", state3, S_WAIT_CLEAR);
        tick();                              // edge 10
        tick();                              // edge 11
        check("back_to_idle", state3, S_IDLE);
        mm = 1'b1;
        repeat (5) tick();                   // edges 12..16
        mm = 1'b0;
        check("second_req_early", req3, 0);
        tick();                              // edge 17
        check("second_req", req3, 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        tick();
        check("persist_event", event_cnt3, 2);
        check("persist_cycle", cycle_cnt3, 14);
        check("persist_end_req", req3, 0);
        check("persist_end_state", state3, S_IDLE);

        // ---- saturation ----
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            mm = 1'b1;
            tick();
            mm = 1'b0;
            tick();
        end
        tick();
        tick();
        check("sat_event", event_cnt3, 15);
        check("sat_cycle", cycle_cnt3, 15);

        // ---- clear against a simultaneous increment ----
        clr = 1'b1;
        tick();
        clr = 1'b0;
        mm = 1'b1;
        tick();
        mm = 1'b0;
        clr = 1'b1;                          // same edge as both increments
        tick();
        clr = 1'b0;
        check("clr_race_event", event_cnt3, 0);
        check("clr_race_cycle", cycle_cnt3, 0);
        tick();
        tick();
        check("clr_after_cycle", cycle_cnt3, 0);

        // ---- reset in the middle of a request ----
        drive_q3(3'b110);
        mm = 1'b1;
        repeat (7) tick();
        check("midrst_pre_req", req3, 1);
        check("midrst_pre_cycle", cycle_cnt3, 6);
        check("midrst_pre_vote", {voted3, faulty3}, 4'b1001);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_req", req3, 0);
        check("midrst_state", state3, S_IDLE);
        check("midrst_vote", {voted3, faulty3}, 4'b0000);
        check("midrst_event", event_cnt3, 0);
        check("midrst_cycle", cycle_cnt3, 0);
        mm = 1'b0;
        ack = 1'b1;
        drive_q3(3'b111);
        tick();
        rst = 1'b0;
        tick();                              // first edge after release
        check("release_vote", {voted3, faulty3}, 4'b1000);
        tick();
        ack = 1'b0;
        check("late_ack_req", req3, 0);
        check("late_ack_state", state3, S_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mmr_mismatch_monitor.md
Name: mmr_mismatch_monitor

Overview:
- Sits directly downstream of an mmr_register instance.
- Consumes the K_MMR replica outputs (Q_o) and the mismatch flag (mismatch_o) of that register.
- Produces a registered majority-voted bit and a per-replica fault map.
- Keeps saturating upset statistics.
- Raises a scrub request via a req/ack handshake when a mismatch persists, so control logic can rewrite the register.

Parameters:
- K_MMR, 3: replica count; odd and >=3, otherwise an elaboration-time $error.
- CNT_WIDTH, 16: width of both statistics counters.
- PERSIST_CYCLES, 4: threshold for the persistence counter before a scrub request; range 1..255.
- RESET_VALUE, 1'b0: reset value of voted_o; matches the upstream register's RESET_VALUE.

Ports:
- clk_i  input  1  single clock.
- rst_i  input  1  reset, asynchronous, active-high.
- Q_i  input  unpacked [K_MMR-1:0] x 1  replica outputs of the upstream mmr_register.
- mismatch_i  input  1  mismatch_o of the upstream mmr_register.
- clear_i  input  1  synchronous clear of the statistics counters.
- scrub_ack_i  input  1  scrub acknowledge from control logic.
- voted_o  output  1  registered majority of Q_i.
- faulty_o  output  K_MMR  registered; bit k = (Q_i[k] != majority).
- event_cnt_o  output  CNT_WIDTH  count of mismatch rising edges, saturating.
- cycle_cnt_o  output  CNT_WIDTH  count of cycles with mismatch high, saturating.
- scrub_req_o  output  1  scrub request, registered.

Behaviour:
- Reset (rst_i=1, asynchronous, any time including mid-handshake):
  - voted_o=RESET_VALUE; faulty_o=0; event_cnt_o=0; cycle_cnt_o=0; scrub_req_o=0.
  - Internal mm_r=0, mm_prev=0, pcnt=0; FSM=IDLE.
  - Everything releases on the first edge after rst_i falls.
- Voting:
  - majority = 1 iff popcount(Q_i) > K_MMR/2.
  - voted_o and faulty_o update on every edge, with 1-cycle latency from Q_i.
  - Inputs containing X/Z are not required to be handled.
- Input stage:
  - mm_r <= mismatch_i and mm_prev <= mm_r every edge.
  - All remaining logic uses mm_r and mm_prev only; mismatch_i is never used combinationally.
- cycle_cnt:
  - Increments on each edge where mm_r=1.
  - Holds at 2^CNT_WIDTH-1.
- event_cnt:
  - Increments on each edge where mm_r=1 and mm_prev=0.
  - Holds at 2^CNT_WIDTH-1.
- clear_i:
  - On an edge with clear_i=1, both counters load 0.
  - Clear wins over a simultaneous increment.
  - No effect on the FSM, pcnt or scrub_req_o.
- FSM states: IDLE, PERSIST, REQ, WAIT_CLEAR.
  - IDLE: if mm_r=1 -> PERSIST and pcnt<=1; else stay.
  - PERSIST:
    - if mm_r=0 -> IDLE and pcnt<=0;
    - else if pcnt==PERSIST_CYCLES -> REQ;
    - else pcnt<=pcnt+1.
  - REQ: scrub_req_o=1; if scrub_ack_i=1 -> WAIT_CLEAR; else stay. A mismatch dropping in REQ does not withdraw the request.
  - WAIT_CLEAR: scrub_req_o=0; if mm_r=0 -> IDLE and pcnt<=0; else stay. Prevents re-requesting on the same fault.
- scrub_req_o is registered; it is 1 exactly while the FSM is in REQ.
- scrub_ack_i is ignored outside REQ.
- Timing: if mismatch_i is sampled high on edges e..e+PERSIST_CYCLES inclusive, scrub_req_o is high after edge e+PERSIST_CYCLES+1. Any low sample before that returns the FSM to IDLE with no request.
- Ack timing: with ack sampled at edge a, scrub_req_o is low after edge a. Back-to-back requests need mm_r=0 for at least one edge in between.

Test Plan:
- Reset/release (K_MMR=3, RESET_VALUE=0):
  - Assert rst_i mid-cycle -> all outputs 0 immediately, without a clock edge.
  - After release, drive Q_i={1,1,1} -> voted_o=1 and faulty_o=000 one edge later.
- Single-replica upset:
  - Q_i={0,1,1} -> voted_o=1, faulty_o=001.
  - Q_i={1,0,0} -> voted_o=0, faulty_o=001.
  - K_MMR=5 with Q_i={1,1,0,0,1} -> voted_o=1, faulty_o=01100.
- Glitch filtering: mismatch_i high for 1 sample, then low -> event_cnt_o=1, cycle_cnt_o=1, scrub_req_o never asserts.
- Persistent fault, PERSIST_CYCLES=4:
  - mismatch_i held high from edge 0 -> scrub_req_o high after edge 5.
  - scrub_ack_i pulsed at edge 8 -> scrub_req_o low after edge 8; it stays low while mismatch_i stays high.
  - Drop mismatch_i, then raise it again for 5 samples -> second request.
  - Final counts: event_cnt_o=2; cycle_cnt_o = total high samples.
- Saturation and clear, CNT_WIDTH=4:
  - mismatch_i toggled for 20 rising events -> event_cnt_o stops at 15.
  - clear_i asserted on the same edge as an increment -> both counters 0.
- Reset mid-handshake: assert rst_i while in REQ -> scrub_req_o=0 and FSM in IDLE; a late scrub_ack_i after release is ignored.
